// File: rtl/sr_bank_pkg.sv
// Shared types and helpers for the sr_latch_bank slice.
// Holds the S=R=1 mode enum, the filter limit and the resolution function.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        SR_HOLD,
        SR_SET_DOM,
        SR_RST_DOM,
        SR_TOGGLE
    } sr_mode_e;

    localparam int FILT_MAX = 15;

    function automatic logic sr_next(
        input sr_mode_e mode,
        input logic     q,
        input logic     s,
        input logic     r
    );
        logic nx;
        nx = q;
        case ({s, r})
            2'b10: nx = 1'b1;
            2'b01: nx = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: nx = 1'b1;
                    SR_RST_DOM: nx = 1'b0;
                    SR_TOGGLE:  nx = ~q;
                    default:    nx = q;
                endcase
            end
            default: nx = q;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One gated set/reset channel with an optional input stability filter.
// Emits its stored bit and a flag for a qualified S=R=1 pair.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter sr_mode_e MODE = SR_HOLD,
    parameter int       FILT = 0,
    parameter logic     INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic coll
);

    logic [1:0] qual;

    generate
        if (FILT > 0) begin : g_filt
            localparam int FC = (FILT > FILT_MAX) ? FILT_MAX : FILT;
            localparam logic [3:0] FL = 4'(FC);

            logic [1:0] cand;
            logic [3:0] cnt;
            logic [3:0] cnt_nx;

            // Count including the current sample, so F+1 samples act on edge k+F.
            always_comb begin
                cnt_nx = 4'd0;
                if ({s, r} == cand) begin
                    cnt_nx = (cnt == FL) ? FL : cnt + 4'd1;
                end
            end

            assign qual = (cnt_nx == FL) ? {s, r} : 2'b00;

            // Candidate pair and stability count; runs regardless of en.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cand <= 2'b00;
                    cnt  <= 4'd0;
                end else begin
                    cand <= {s, r};
                    cnt  <= cnt_nx;
                end
            end
        end else begin : g_raw
            assign qual = {s, r};
        end
    endgenerate

    // Stored bit: resolved from the qualified pair when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INIT;
        end else if (en) begin
            q <= sr_next(MODE, q, qual[1], qual[0]);
        end
    end

    assign coll = &qual;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N clocked set/reset cells with collision flag and counter.
// Define SR_LATCH_BANK_COLL_CNT_EN to build the saturating collision counter.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int             N     = 8,
    parameter sr_mode_e       MODE  = SR_HOLD,
    parameter int             FILT  = 0,
    parameter logic [N-1:0]   INIT  = '0,
    parameter int             CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             clr_coll,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qbar,
    output logic             coll,
    output logic [CNT_W-1:0] coll_cnt
);

    logic [N-1:0] cell_coll;
    logic         coll_now;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_cell #(
            .MODE (MODE),
            .FILT (FILT),
            .INIT (INIT[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .s     (s[i]),
            .r     (r[i]),
            .q     (q[i]),
            .coll  (cell_coll[i])
        );
    end

    assign qbar     = ~q;
    assign coll_now = en & (|cell_coll);

    // Sticky collision flag; a clear still records a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll <= 1'b0;
        end else if (clr_coll) begin
            coll <= coll_now;
        end else if (coll_now) begin
            coll <= 1'b1;
        end
    end

`ifdef SR_LATCH_BANK_COLL_CNT_EN
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Saturating count of collision cycles, restarted by clr_coll.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (clr_coll) begin
            coll_cnt <= coll_now ? ONE : '0;
        end else if (coll_now && coll_cnt != CMAX) begin
            coll_cnt <= coll_cnt + ONE;
        end
    end
`else
    assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed self-checking bench for sr_latch_bank.
// Several parameterisations share one stimulus stream.
module tb_sr_latch_bank;
    import sr_bank_pkg::*;

`ifdef SR_LATCH_BANK_COLL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr;

    logic [3:0] q_h, qb_h, q_s, qb_s, q_r, qb_r, q_t, qb_t;
    logic [3:0] q_c, qb_c, q_f, qb_f;
    logic       c_h, c_s, c_r, c_t, c_c, c_f;
    logic [7:0] n_h, n_s, n_r, n_t, n_f;
    logic [1:0] n_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sr_latch_bank #(.N(4), .MODE(SR_HOLD), .FILT(0),
                    .INIT(4'b0000), .CNT_W(8)) u_h (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
        .clr_coll(clr), .q(q_h), .qbar(qb_h),
        .coll(c_h), .coll_cnt(n_h));

    sr_latch_bank #(.N(4), .MODE(SR_SET_DOM), .FILT(0),
                    .INIT(4'b0000), .CNT_W(8)) u_s (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
        .clr_coll(clr), .q(q_s), .qbar(qb_s),
        .coll(c_s), .coll_cnt(n_s));

    sr_latch_bank #(.N(4), .MODE(SR_RST_DOM), .FILT(0),
                    .INIT(4'b0000), .CNT_W(8)) u_r (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
        .clr_coll(clr), .q(q_r), .qbar(qb_r),
        .coll(c_r), .coll_cnt(n_r));

    sr_latch_bank #(.N(4), .MODE(SR_TOGGLE), .FILT(0),
                    .INIT(4'b0000), .CNT_W(8)) u_t (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
        .clr_coll(clr), .q(q_t), .qbar(qb_t),
        .coll(c_t), .coll_cnt(n_t));

    sr_latch_bank #(.N(4), .MODE(SR_HOLD), .FILT(0),
                    .INIT(4'b0000), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
        .clr_coll(clr), .q(q_c), .qbar(qb_c),
        .coll(c_c), .coll_cnt(n_c));

    sr_latch_bank #(.N(4), .MODE(SR_TOGGLE), .FILT(3),
                    .INIT(4'b1010), .CNT_W(8)) u_f (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
        .clr_coll(clr), .q(q_f), .qbar(qb_f),
        .coll(c_f), .coll_cnt(n_f));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ec(input int v);
        return CNT_ON ? 64'(v) : 64'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        s     = 4'b0000;
        r     = 4'b0000;
        clr   = 1'b0;
        #12;
        chk("rst_q_h",    64'(q_h),  64'h0);
        chk("rst_qb_h",   64'(qb_h), 64'hf);
        chk("rst_coll_h", 64'(c_h),  64'h0);
        chk("rst_cnt_h",  64'(n_h),  64'h0);
        chk("rst_q_f",    64'(q_f),  64'ha);
        chk("rst_qb_f",   64'(qb_f), 64'h5);
        rst_n = 1'b1;

        // Basic set then clear
        en = 1'b1; s = 4'b0101; r = 4'b0000;
        step();
        chk("set_q",  64'(q_h),  64'h5);
        chk("set_qb", 64'(qb_h), 64'ha);
        s = 4'b0000; r = 4'b0001;
        step();
        chk("clr_q", 64'(q_h), 64'h4);

        // Gate closed
        en = 1'b0; s = 4'b1111; r = 4'b0000;
        step();
        chk("gate_q1", 64'(q_h), 64'h4);
        step();
        chk("gate_q2", 64'(q_h), 64'h4);
        step();
        chk("gate_q3",    64'(q_h), 64'h4);
        chk("gate_coll",  64'(c_h), 64'h0);

        // S=R=1 per mode
        s = 4'b0000;
        rst_pulse();
        en = 1'b1; s = 4'b0001; r = 4'b0001;
        step();
        chk("hold_1", 64'(q_h[0]), 64'h0);
        chk("sdom_1", 64'(q_s[0]), 64'h1);
        chk("rdom_1", 64'(q_r[0]), 64'h0);
        chk("tog_1",  64'(q_t[0]), 64'h1);
        chk("sat_1",  64'(n_c),    ec(1));
        step();
        chk("hold_2", 64'(q_h[0]), 64'h0);
        chk("sdom_2", 64'(q_s[0]), 64'h1);
        chk("rdom_2", 64'(q_r[0]), 64'h0);
        chk("tog_2",  64'(q_t[0]), 64'h0);
        chk("sat_2",  64'(n_c),    ec(2));
        step();
        chk("hold_3", 64'(q_h[0]), 64'h0);
        chk("sdom_3", 64'(q_s[0]), 64'h1);
        chk("rdom_3", 64'(q_r[0]), 64'h0);
        chk("tog_3",  64'(q_t[0]), 64'h1);
        chk("coll_h", 64'(c_h), 64'h1);
        chk("coll_s", 64'(c_s), 64'h1);
        chk("coll_r", 64'(c_r), 64'h1);
        chk("coll_t", 64'(c_t), 64'h1);
        chk("cnt_h",  64'(n_h), ec(3));
        chk("cnt_s",  64'(n_s), ec(3));
        chk("cnt_r",  64'(n_r), ec(3));
        chk("cnt_t",  64'(n_t), ec(3));
        chk("sat_3",  64'(n_c), ec(3));

        // Saturation and clear
        step();
        step();
        chk("sat_5",   64'(n_c), ec(3));
        chk("cnt_h5",  64'(n_h), ec(5));
        clr = 1'b1;
        step();
        chk("clrc_coll", 64'(c_c), 64'h1);
        chk("clrc_cnt",  64'(n_c), ec(1));
        s = 4'b0000; r = 4'b0000;
        step();
        chk("clr_coll", 64'(c_c), 64'h0);
        chk("clr_cnt",  64'(n_c), 64'h0);
        clr = 1'b0;

        // Filter: short pulse rejected, full-length pulse accepted
        rst_pulse();
        s = 4'b0100;
        step();
        chk("fs_1", 64'(q_f), 64'ha);
        step();
        chk("fs_2", 64'(q_f), 64'ha);
        step();
        chk("fs_3", 64'(q_f), 64'ha);
        s = 4'b0000;
        step();
        chk("fs_end", 64'(q_f), 64'ha);
        s = 4'b0100;
        step();
        chk("fl_1", 64'(q_f), 64'ha);
        step();
        chk("fl_2", 64'(q_f), 64'ha);
        step();
        chk("fl_3", 64'(q_f), 64'ha);
        step();
        chk("fl_4", 64'(q_f), 64'he);

        // Filtered toggle, then reset in the middle of it
        s = 4'b0001; r = 4'b0001;
        step();
        step();
        step();
        chk("ft_3", 64'(q_f), 64'he);
        step();
        chk("ft_4",    64'(q_f), 64'hf);
        chk("ft_coll", 64'(c_f), 64'h1);
        chk("ft_cnt4", 64'(n_f), ec(1));
        step();
        chk("ft_5",    64'(q_f), 64'he);
        chk("ft_cnt5", 64'(n_f), ec(2));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_q",    64'(q_f),  64'ha);
        chk("ar_qb",   64'(qb_f), 64'h5);
        chk("ar_coll", 64'(c_f),  64'h0);
        chk("ar_cnt",  64'(n_f),  64'h0);
        #2 rst_n = 1'b1;
        step();
        chk("rr_1", 64'(q_f), 64'ha);
        step();
        chk("rr_2", 64'(q_f), 64'ha);
        step();
        chk("rr_3",    64'(q_f), 64'ha);
        chk("rr_coll", 64'(c_f), 64'h0);
        step();
        chk("rr_4",    64'(q_f), 64'hb);
        chk("rr_c4",   64'(c_f), 64'h1);
        chk("rr_n4",   64'(n_f), ec(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised bank of N clocked, gated set/reset storage cells, the synchronous successor of the single gated SR element. Each channel holds one bit, driven by its own S/R pair and qualified by a shared enable. It adds a selectable S=R=1 resolution mode, an optional per-channel input stability filter, and collision tracking. It sits between raw control/status sources and the register/interrupt logic that consumes sticky bits.

## Interface
- `N`, default 8: number of channels, 1..64.
- `MODE`, default `SR_HOLD`: S=R=1 resolution: `SR_HOLD`, `SR_SET_DOM`, `SR_RST_DOM` or `SR_TOGGLE` (JK behaviour).
- `FILT`, default 0: stability filter length in cycles, 0..15. 0 bypasses the filter.
- `INIT`, default all zeros: N-bit reset value of `q`.
- `CNT_W`, default 8: collision counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  gate; when 0, `q` holds regardless of S/R.
- `s`  in  N  per-channel set.
- `r`  in  N  per-channel reset.
- `clr_coll`  in  1  synchronous clear of collision flag and counter.
- `q`  out  N  stored bits.
- `qbar`  out  N  always `~q`, never independent state.
- `coll`  out  1  sticky: a collision has been applied since the last clear.
- `coll_cnt`  out  CNT_W  saturating count of collision cycles (macro-dependent).

## Operation
- Reset values: `q` = `INIT`, `qbar` = `~INIT`, `coll` = 0, `coll_cnt` = 0, all filter state cleared (candidate pair = 00, count = 0).
- Filter with FILT = F > 0, per channel:
  - If the sampled {s,r} differs from the stored candidate, the candidate takes the new value and the count goes to 0.
  - Otherwise the count increments and saturates at F.
  - The qualified pair equals the candidate when count == F, else 00 (no action).
  - The filter runs whether or not `en` is high.
- With F = 0, the qualified pair is the raw {s,r}.
- Next-state per channel when `en` = 1, using qualified {s,r}:
  - 00: hold.
  - 10: set to 1.
  - 01: clear to 0.
  - 11: per MODE. `SR_HOLD` holds, `SR_SET_DOM` gives 1, `SR_RST_DOM` gives 0, `SR_TOGGLE` inverts on every enabled cycle the pair persists.
- When `en` = 0: every channel holds.
- A collision cycle is one where `en` = 1 and at least one channel has qualified 11. It is counted once per cycle, not once per channel.
- A collision cycle sets `coll`.
- `clr_coll` has priority over set. If `clr_coll` and a collision occur in the same cycle, the result is `coll` = 1 and `coll_cnt` = 1.

## Timing
- F = 0: `q` reflects the S/R sampled at edge k immediately after edge k (1-cycle latency).
- F > 0: a pair held stable through edges k..k+F acts at edge k+F, so `q` changes after edge k+F. The pair must be sampled F+1 times.
- A pair change before count reaches F restarts qualification. A pulse shorter than F+1 cycles never acts.
- `coll` and `coll_cnt` update on the same edge as the `q` update that caused them.
- `rst_n` asserted mid-operation forces reset values immediately, asynchronously. Release is taken on the next `clk` edge with filters empty.
- Counter saturation: at 2^CNT_W−1 the counter stays there. Only `clr_coll` or reset lowers it.

## Configuration
- `SR_LATCH_BANK_COLL_CNT_EN` defined: the collision counter is built and `coll_cnt` behaves as in Operation.
- Macro undefined: no counter registers; `coll_cnt` is tied to 0. `coll` is still built and behaves identically.

## Structure
- Shared package `sr_bank_pkg` holds:
  - the `sr_mode_e` enum (`SR_HOLD`, `SR_SET_DOM`, `SR_RST_DOM`, `SR_TOGGLE`);
  - the `FILT_MAX` = 15 constant;
  - the `sr_next()` resolution function shared with the reference model.
- One sub-module, `sr_cell`, built by a generate loop N times. Each instance contains the filter candidate/count and the q bit, and outputs its own q and qualified-collision bit.
- Top level holds the OR-reduction, `coll` and the counter.

## Test plan
- N=4, INIT=4'b0000, F=0, MODE=`SR_HOLD`, en=1: s=4'b0101 for 1 cycle → q=4'b0101 and qbar=4'b1010 after the next edge. Then r=4'b0001 → q=4'b0100.
- en=0, s=4'b1111 for 3 cycles → q unchanged; coll stays 0.
- Each MODE with q[0]=0 and s[0]=r[0]=1 for 3 enabled cycles → q[0] is:
  - `SR_HOLD`: 0,0,0;
  - `SR_SET_DOM`: 1,1,1;
  - `SR_RST_DOM`: 0,0,0;
  - `SR_TOGGLE`: 1,0,1.
  - In all modes coll=1 and coll_cnt=3.
- F=3: s[2]=1 for 3 cycles then 0 → q[2] stays 0. s[2]=1 for 4 cycles → q[2]=1 after the 4th edge.
- CNT_W=2, 5 collision cycles → coll_cnt saturates at 3. Then `clr_coll` together with a collision → coll=1, coll_cnt=1. Then `clr_coll` alone → both 0.
- Assert `rst_n` low mid-filter and mid-toggle with INIT=4'b1010 → q=4'b1010, coll=0 and coll_cnt=0 immediately. After release, a held s needs the full F+1 samples again.
